// File: rtl/vga_sync.sv
// VGA timing generator: pixel-rate divider, h/v position counters and
// sync/visible decode taken straight from the counter registers.
module vga_sync #(
    parameter int CLK_DIV  = 2,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 29,
    parameter int V_ACTIVE = 480
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_tick,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       bright,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int H_TOTAL = H_FP + H_SYNC + H_BP + H_ACTIVE;
    localparam int V_TOTAL = V_FP + V_SYNC + V_BP + V_ACTIVE;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_BEG  = 10'(H_FP);
    localparam logic [9:0] HS_END  = 10'(H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG  = 10'(V_FP);
    localparam logic [9:0] VS_END  = 10'(V_FP + V_SYNC - 1);
    localparam logic [9:0] H_VIS   = 10'(H_FP + H_SYNC + H_BP);
    localparam logic [9:0] V_VIS   = 10'(V_FP + V_SYNC + V_BP);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]    h_count_q, h_count_d;
    logic [9:0]    v_count_q, v_count_d;
    logic          div_last;

    // Gating with rst keeps the strobe low during reset even when CLK_DIV is 1.
    assign div_last = (div_cnt_q == DIV_LAST);
    assign pix_tick = div_last & ~rst;

    always_comb begin
        div_cnt_d = div_last ? '0 : div_cnt_q + 1'b1;
        h_count_d = h_count_q;
        v_count_d = v_count_q;
        if (pix_tick) begin
            if (h_count_q == H_LAST) begin
                h_count_d = '0;
                v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + 10'd1;
            end else begin
                h_count_d = h_count_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            h_count_q <= '0;
            v_count_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            h_count_q <= h_count_d;
            v_count_q <= v_count_d;
        end
    end

    assign h_count     = h_count_q;
    assign v_count     = v_count_q;
    assign hsync       = ~((h_count_q >= HS_BEG) && (h_count_q <= HS_END));
    assign vsync       = ~((v_count_q >= VS_BEG) && (v_count_q <= VS_END));
    assign bright      = (h_count_q >= H_VIS) && (v_count_q >= V_VIS);
    assign frame_start = pix_tick && (h_count_q == '0) && (v_count_q == '0);

endmodule
